// File: rtl/uart_config_pkg.sv
// rtl/uart_config_pkg.sv - shared command codes, reset defaults and receiver states
package uart_config_pkg;

    localparam logic [3:0] CMD_PARITY = 4'h9;
    localparam logic [3:0] CMD_FLEN   = 4'hC;
    localparam logic [3:0] CMD_BAUD   = 4'h1;
    localparam logic [3:0] READ_CODE  = 4'hF;

    localparam int CLK_PER_BIT_BASE_RST = 16;
    localparam int BAUD_RST             = 1;
    localparam int PARITY_RST           = 1;
    localparam int FLEN_RST             = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_config_top_rx.sv
// rtl/uart_config_top_rx.sv - UART receiver with synchronizer, bit timer and frame checking
module uart_rx
    import uart_config_pkg::*;
#(
    parameter int CLK_PER_BIT_BASE = CLK_PER_BIT_BASE_RST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       parity_en,
    input  logic [3:0] flen,
    input  logic [1:0] baud,
    output logic       byte_valid,
    output logic [8:0] frame
);

    rx_state_t   state;
    logic        rx_s1;
    logic        rx_s2;
    logic        par_l;
    logic [3:0]  flen_l;
    logic [1:0]  baud_l;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  data;
    logic        par_bit;
    logic [15:0] bit_len;
    logic [15:0] half_len;

    // Timing uses the config captured at the start edge so writes never disturb a frame in flight.
    assign bit_len  = 16'(CLK_PER_BIT_BASE) << baud_l;
    assign half_len = bit_len >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            par_l      <= 1'b0;
            flen_l     <= 4'd0;
            baud_l     <= 2'd0;
            cnt        <= 16'd0;
            bit_idx    <= 3'd0;
            data       <= 8'd0;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            frame      <= 9'd0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            byte_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        par_l  <= parity_en;
                        flen_l <= flen;
                        baud_l <= baud;
                        cnt    <= 16'd0;
                        state  <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == half_len - 16'd1) begin
                        cnt <= 16'd0;
                        if (!rx_s2) begin
                            state   <= RX_DATA;
                            bit_idx <= 3'd0;
                            data    <= 8'd0;
                            par_bit <= 1'b0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == bit_len - 16'd1) begin
                        cnt           <= 16'd0;
                        data[bit_idx] <= rx_s2;
                        bit_idx       <= bit_idx + 3'd1;
                        if ({1'b0, bit_idx} == flen_l - 4'd1)
                            state <= par_l ? RX_PARITY : RX_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_PARITY: begin
                    if (cnt == bit_len - 16'd1) begin
                        cnt     <= 16'd0;
                        par_bit <= rx_s2;
                        state   <= RX_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == bit_len - 16'd1) begin
                        cnt   <= 16'd0;
                        state <= RX_IDLE;
                        if (rx_s2 && (!par_l || !((^data) ^ par_bit))) begin
                            byte_valid <= 1'b1;
                            frame      <= {par_l & par_bit, data};
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_config_top.sv
// rtl/uart_config_top.sv - UART command processor: receiver, command decoder and config registers
module uart_config_top
    import uart_config_pkg::*;
#(
    parameter int CLK_PER_BIT_BASE = CLK_PER_BIT_BASE_RST,
    parameter int BAUD_DEFAULT     = BAUD_RST,
    parameter int PARITY_DEFAULT   = PARITY_RST,
    parameter int FLEN_DEFAULT     = FLEN_RST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    input  logic       debug,
    output logic [8:0] debug_frame,
    output logic [3:0] debug_reg
);

    logic       parity_en;
    logic [3:0] flen;
    logic [1:0] baud;
    logic [3:0] read_val;
    logic       byte_valid;
    logic [8:0] frame;
    logic [3:0] hi;
    logic [3:0] lo;

    uart_rx #(
        .CLK_PER_BIT_BASE(CLK_PER_BIT_BASE)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (Rx),
        .parity_en  (parity_en),
        .flen       (flen),
        .baud       (baud),
        .byte_valid (byte_valid),
        .frame      (frame)
    );

    assign hi = frame[7:4];
    assign lo = frame[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_en <= PARITY_DEFAULT[0];
            flen      <= FLEN_DEFAULT[3:0];
            baud      <= BAUD_DEFAULT[1:0];
            read_val  <= 4'd0;
        end else if (byte_valid) begin
            case (hi)
                CMD_PARITY: begin
                    if (lo == READ_CODE)
                        read_val <= {3'b000, parity_en};
                    else if (lo[3:1] == 3'b000)
                        parity_en <= lo[0];
                end
                CMD_FLEN: begin
                    if (lo == READ_CODE)
                        read_val <= flen;
                    else if (lo >= 4'd5 && lo <= 4'd8)
                        flen <= lo;
                end
                CMD_BAUD: begin
                    if (lo == READ_CODE)
                        read_val <= {2'b00, baud};
                    else if (lo[3:2] == 2'b00)
                        baud <= lo[1:0];
                end
                default: ;
            endcase
        end
    end

    // Gating only masks the outputs; the underlying registers keep their contents.
    assign debug_frame = debug ? frame    : 9'd0;
    assign debug_reg   = debug ? read_val : 4'd0;

endmodule

// File: tb/tb_uart_config_top.sv
// tb/tb_uart_config_top.sv - scoreboard bench for uart_config_top
module tb_uart_config_top;

    logic       clk;
    logic       rst;
    logic       Rx;
    logic       debug;
    logic [8:0] debug_frame;
    logic [3:0] debug_reg;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [8:0] f;
        logic [3:0] r;
    } exp_t;

    exp_t q[$];

    uart_config_top dut (
        .clk         (clk),
        .rst         (rst),
        .Rx          (Rx),
        .debug       (debug),
        .debug_frame (debug_frame),
        .debug_reg   (debug_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accepted frames are detected on byte_valid; the outputs are compared one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dut.u_rx.byte_valid === 1'b1) begin
                @(negedge clk);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame %h with nothing expected", debug_frame);
                end else begin
                    e = q.pop_front();
                    chk("sb_frame", 16'(debug_frame), 16'(e.f));
                    chk("sb_reg", 16'(debug_reg), 16'(e.r));
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input int nb, input bit has_par, input bit pb,
                        input bit sb, input int cpb, input bit good,
                        input logic [8:0] ef, input logic [3:0] er);
        exp_t e;
        if (good) begin
            e.f = ef;
            e.r = er;
            q.push_back(e);
        end
        Rx = 1'b0;
        repeat (cpb) @(posedge clk);
        for (int i = 0; i < nb; i++) begin
            Rx = d[i];
            repeat (cpb) @(posedge clk);
        end
        if (has_par) begin
            Rx = pb;
            repeat (cpb) @(posedge clk);
        end
        Rx = sb;
        repeat (cpb) @(posedge clk);
        Rx = 1'b1;
        repeat (2 * cpb) @(posedge clk);
        for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        Rx    = 1'b1;
        debug = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_frame", 16'(debug_frame), 16'h000);
        chk("rst_reg", 16'(debug_reg), 16'h0);
        chk("rst_parity", 16'(dut.parity_en), 16'h1);
        chk("rst_flen", 16'(dut.flen), 16'h8);
        chk("rst_baud", 16'(dut.baud), 16'h1);
        repeat (10) @(posedge clk);

        send(8'h90, 8, 1, 0, 1, 32, 1, 9'h090, 4'h0);
        chk("parity_off", 16'(dut.parity_en), 16'h0);
        send(8'h9F, 8, 0, 0, 1, 32, 1, 9'h09F, 4'h0);
        send(8'h75, 8, 0, 0, 1, 32, 1, 9'h075, 4'h0);
        send(8'h91, 8, 0, 0, 1, 32, 1, 9'h091, 4'h0);
        chk("parity_on", 16'(dut.parity_en), 16'h1);
        send(8'h9F, 8, 1, 0, 1, 32, 1, 9'h09F, 4'h1);

        @(negedge clk) debug = 1'b0;
        repeat (100) @(negedge clk);
        chk("dbg_off_frame", 16'(debug_frame), 16'h000);
        chk("dbg_off_reg", 16'(debug_reg), 16'h0);
        debug = 1'b1;
        @(negedge clk);
        chk("dbg_on_frame", 16'(debug_frame), 16'h09F);
        chk("dbg_on_reg", 16'(debug_reg), 16'h1);

        send(8'hCF, 8, 1, 0, 1, 32, 1, 9'h0CF, 4'h8);
        send(8'h1F, 8, 1, 1, 1, 32, 1, 9'h11F, 4'h1);
        send(8'h12, 8, 1, 0, 1, 32, 1, 9'h012, 4'h1);
        chk("baud2", 16'(dut.baud), 16'h2);
        send(8'h1F, 8, 1, 1, 1, 64, 1, 9'h11F, 4'h2);

        send(8'hC7, 8, 1, 1, 1, 64, 1, 9'h1C7, 4'h2);
        chk("flen7", 16'(dut.flen), 16'h7);
        send(8'h1F, 7, 1, 1, 1, 64, 1, 9'h11F, 4'h2);

        send(8'h75, 7, 1, 0, 1, 64, 0, 9'h000, 4'h0);
        chk("bad_parity", 16'(debug_frame), 16'h11F);
        send(8'h75, 7, 1, 1, 0, 64, 0, 9'h000, 4'h0);
        repeat (200) @(posedge clk);
        chk("bad_stop", 16'(debug_frame), 16'h11F);
        Rx = 1'b0;
        repeat (8) @(posedge clk);
        Rx = 1'b1;
        repeat (300) @(posedge clk);
        chk("glitch", 16'(debug_frame), 16'h11F);

        Rx = 1'b0;
        repeat (150) @(posedge clk);
        #1 rst = 1'b1;
        Rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_frame", 16'(debug_frame), 16'h000);
        chk("mid_rst_reg", 16'(debug_reg), 16'h0);
        chk("mid_rst_flen", 16'(dut.flen), 16'h8);
        chk("mid_rst_baud", 16'(dut.baud), 16'h1);
        repeat (300) @(posedge clk);
        chk("sb_empty", 16'(q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
